count_sched: RTL and testbench

Sequencer and arbiter for the shared bounded up-counter resource. Two requesters each submit a run (start value, end value). The block grants runs round-robin and steps the counter from start to end, one step per clock. It then issues a tagged completion pulse. It replaces free-running self-terminating counter loops with a reusable, handshaked controller.

---
 rtl/count_sched_pkg.sv | 17 +
 rtl/count_sched_rr_arb2.sv | 15 +
 rtl/count_sched.sv | 105 ++++++++++
 tb/tb_count_sched.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared definitions for the count_sched run sequencer: state encoding,
// default operand sizing and requester ids.
package count_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_STEP  = 1;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/count_sched_rr_arb2.sv
// Two-way round-robin pick. Purely combinational; the caller owns the
// last-served pointer.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_id,
  output logic valid,
  output logic id
);

  assign valid = req0 | req1;
  // On contention the requester not served last wins.
  assign id    = (req0 & req1) ? ~last_id : req1;

endmodule

// File: rtl/count_sched.sv
// Round-robin sequencer for a shared bounded up-counter: grants one run at a
// time, steps start..end one STEP per clock, then pulses a tagged done.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] start0,
  input  logic [WIDTH-1:0] end0,
  input  logic             req1,
  input  logic [WIDTH-1:0] start1,
  input  logic [WIDTH-1:0] end1,
  input  logic             hold,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             done_id,
  output logic             err
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t           state, state_nx;
  logic [WIDTH-1:0] run_end;
  logic             run_id;
  logic             last_id;
  logic             arb_vld, arb_id;
  logic [WIDTH-1:0] sel_start, sel_end, sel_diff;
  logic             sel_bad;
  logic             at_end;

  rr_arb2 u_arb (
    .req0    (req0),
    .req1    (req1),
    .last_id (last_id),
    .valid   (arb_vld),
    .id      (arb_id)
  );

  assign sel_start = arb_id ? start1 : start0;
  assign sel_end   = arb_id ? end1   : end0;
  assign sel_diff  = sel_end - sel_start;
  // Reject reversed ranges and ranges the step cannot land on exactly.
  assign sel_bad   = (sel_end < sel_start) || ((sel_diff % STEP_W) != '0);
  assign at_end    = (count == run_end);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (arb_vld) state_nx = sel_bad ? S_DONE : S_RUN;
      S_RUN:  if (!hold && at_end) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      grant   <= 2'b00;
      count   <= '0;
      run_end <= '0;
      run_id  <= ID_REQ0;
      last_id <= ID_REQ1;
      done    <= 1'b0;
      done_id <= ID_REQ0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      grant <= 2'b00;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: if (arb_vld) begin
          count   <= sel_start;
          run_end <= sel_end;
          run_id  <= arb_id;
          grant   <= (arb_id == ID_REQ1) ? 2'b10 : 2'b01;
          if (sel_bad) begin
            done    <= 1'b1;
            err     <= 1'b1;
            done_id <= arb_id;
          end
        end
        S_RUN: if (!hold) begin
          if (at_end) begin
            done    <= 1'b1;
            done_id <= run_id;
          end else begin
            count <= count + STEP_W;
          end
        end
        S_DONE: last_id <= run_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: a queue-based run model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_count_sched;
  localparam int WIDTH = 8;
  localparam int STEP  = 1;

  logic             clk = 1'b0;
  logic             rst_n, req0, req1, hold;
  logic [WIDTH-1:0] start0, end0, start1, end1;
  logic [1:0]       grant;
  logic             busy, done, done_id, err;
  logic [WIDTH-1:0] count;

  int checks = 0, failures = 0;

  count_sched #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .start0(start0), .end0(end0),
    .req1(req1), .start1(start1), .end1(end1),
    .hold(hold), .grant(grant), .busy(busy), .count(count),
    .done(done), .done_id(done_id), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Run-level model: a run is the list of values it must show; hold repeats
  // the current value, an empty list means the completion cycle is next.
  int  cyc = 0;
  bit  m_ok = 0;
  int  m_ph = 0;          // 0 idle, 1 running, 2 completing
  int  m_last = 1, m_cur = 0;
  int  q[$];
  int  e_grant, e_busy, e_count, e_done, e_err, e_id;

  always @(posedge clk) begin
    int w, s, e;
    cyc++;
    if (!rst_n) begin
      m_ok = 1; m_ph = 0; m_last = 1; q.delete();
      e_grant = 0; e_busy = 0; e_count = 0; e_done = 0; e_err = 0; e_id = 0;
    end else begin
      e_grant = 0; e_done = 0; e_err = 0;
      case (m_ph)
        0: if (req0 || req1) begin
          w = (req0 && req1) ? 1 - m_last : int'(req1);
          s = w ? int'(start1) : int'(start0);
          e = w ? int'(end1)   : int'(end0);
          m_cur = w; e_grant = w ? 2 : 1; e_count = s; e_busy = 1;
          if (e < s || (e - s) % STEP != 0) begin
            m_ph = 2; e_done = 1; e_err = 1; e_id = w;
          end else begin
            q.delete();
            for (int v = s + STEP; v <= e; v += STEP) q.push_back(v);
            m_ph = 1;
          end
        end
        1: if (!hold) begin
          if (q.size() > 0) e_count = q.pop_front();
          else begin m_ph = 2; e_done = 1; e_id = m_cur; end
        end
        default: begin m_ph = 0; e_busy = 0; m_last = m_cur; end
      endcase
    end
  end

  always @(negedge clk) if (m_ok) begin
    chk("grant", grant, e_grant);
    chk("busy",  busy,  e_busy);
    chk("count", count, e_count);
    chk("done",  done,  e_done);
    chk("err",   err,   e_err);
    if (e_done) chk("done_id", done_id, e_id);
  end

  task automatic wait_grant(output logic [1:0] g, output int gc);
    int n = 0;
    do begin @(negedge clk); n++; end while (grant == 2'b00 && n < 300);
    if (grant == 2'b00) chk("grant_timeout", 0, 1);
    g = grant; gc = cyc;
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    while (!done && n < 400) begin @(negedge clk); n++; end
    if (!done) chk("done_timeout", 0, 1);
    dc = cyc;
  endtask

  task automatic wait_count(input int v);
    int n = 0;
    while (count != v && n < 300) begin @(negedge clk); n++; end
    if (count != v) chk("count_timeout", count, v);
  endtask

  initial begin
    logic [1:0] g;
    int gc, dc, g1;
    rst_n = 0; req0 = 0; req1 = 0; hold = 0;
    start0 = 0; end0 = 0; start1 = 0; end1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0); chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0); chk("rst_done", done, 0);
    rst_n = 1;

    // 1: single run 10..100
    start0 = 10; end0 = 100; req0 = 1;
    wait_grant(g, gc); req0 = 0;
    chk("t1_grant", g, 1); chk("t1_first", count, 10);
    wait_done(dc);
    chk("t1_len", dc - gc, 91); chk("t1_id", done_id, 0); chk("t1_end", count, 100);
    @(negedge clk); @(negedge clk); chk("t1_busy_low", busy, 0);

    // 2: contention from reset
    rst_n = 0; start0 = 1; end0 = 2; start1 = 3; end1 = 5; req0 = 1; req1 = 1;
    @(negedge clk); rst_n = 1;
    wait_grant(g, gc); req0 = 0; chk("t2_first", g, 1);
    wait_done(dc);
    wait_grant(g, g1); req1 = 0;
    chk("t2_second", g, 2); chk("t2_gap", g1 - dc, 2); chk("t2_c3", count, 3);
    @(negedge clk); chk("t2_c4", count, 4);
    @(negedge clk); chk("t2_c5", count, 5);
    @(negedge clk); chk("t2_done", done, 1); chk("t2_id", done_id, 1);
    req0 = 1; req1 = 1;
    wait_grant(g, gc); chk("t2_rr", g, 1); req0 = 0;
    wait_done(dc);
    wait_grant(g, gc); chk("t2_rr1", g, 2); req1 = 0;
    wait_done(dc);

    // 3: single-value run
    start0 = 7; end0 = 7; req0 = 1;
    wait_grant(g, gc); req0 = 0; chk("t3_count", count, 7);
    wait_done(dc); chk("t3_len", dc - gc, 1); chk("t3_err", err, 0);

    // 4: reversed range rejected
    start1 = 20; end1 = 5; req1 = 1;
    wait_grant(g, gc); req1 = 0;
    chk("t4_grant", g, 2); chk("t4_done", done, 1); chk("t4_err", err, 1);
    chk("t4_id", done_id, 1); chk("t4_count", count, 20);
    @(negedge clk); chk("t4_pulse", done, 0);

    // 5: hold mid-run and at the last value
    start0 = 10; end0 = 100; req0 = 1;
    wait_grant(g, gc); req0 = 0;
    wait_count(50); hold = 1;
    repeat (3) @(negedge clk);
    chk("t5_frozen", count, 50); hold = 0;
    wait_done(dc); chk("t5_len", dc - gc, 94);
    req0 = 1;
    wait_grant(g, gc); req0 = 0;
    wait_count(100); hold = 1;
    repeat (2) @(negedge clk);
    chk("t5_defer", done, 0); hold = 0;
    wait_done(dc); chk("t5_len2", dc - gc, 93);

    // 6: reset mid-run with req still high
    req0 = 1;
    wait_grant(g, gc);
    wait_count(40); rst_n = 0;
    @(negedge clk); rst_n = 1;
    chk("t6_count", count, 0); chk("t6_busy", busy, 0); chk("t6_done", done, 0);
    wait_grant(g, gc); req0 = 0;
    chk("t6_regrant", g, 1); chk("t6_restart", count, 10);
    wait_done(dc); chk("t6_len", dc - gc, 91);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
